// File: rtl/fib_pkg.sv
// Shared types and default widths for the Fibonacci sequencer and its core.
package fib_pkg;

   localparam int FIB_WIDTH = 32;
   localparam int FIB_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } fib_state_e;

endpackage

// File: rtl/fib_core.sv
// Fibonacci state pair (prev, cur) with per-register overflow tags and one adder.
module fib_core
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   output logic [WIDTH-1:0] prev,
   output logic             cur_ovf
);

   logic [WIDTH-1:0] prev_q, prev_d, cur_q, cur_d;
   logic             prev_ovf_q, prev_ovf_d, cur_ovf_q, cur_ovf_d;
   logic [WIDTH-1:0] sum;
   logic             carry;

   always_comb begin
      {carry, sum} = {1'b0, prev_q} + {1'b0, cur_q};
      prev_d     = prev_q;
      cur_d      = cur_q;
      prev_ovf_d = prev_ovf_q;
      cur_ovf_d  = cur_ovf_q;
      if (load) begin
         prev_d     = seed_a;
         cur_d      = seed_b;
         prev_ovf_d = 1'b0;
         cur_ovf_d  = 1'b0;
      end else if (step) begin
         // The tag follows a wrapped value forward so later terms stay marked.
         prev_d     = cur_q;
         prev_ovf_d = cur_ovf_q;
         cur_d      = sum;
         cur_ovf_d  = carry | prev_ovf_q | cur_ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         cur_q      <= '0;
         prev_ovf_q <= 1'b0;
         cur_ovf_q  <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         cur_q      <= cur_d;
         prev_ovf_q <= prev_ovf_d;
         cur_ovf_q  <= cur_ovf_d;
      end
   end

   assign prev    = prev_q;
   assign cur_ovf = cur_ovf_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Job sequencer: loads the Fibonacci core, streams terms over valid/ready and stops before a wrapped term.
module fib_seq_ctrl
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH,
   parameter int CNT_W = FIB_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_terms,
   input  logic [WIDTH-1:0] seed_a,
   input  logic [WIDTH-1:0] seed_b,
   input  logic             abort,
   output logic [WIDTH-1:0] term,
   output logic [CNT_W-1:0] term_idx,
   output logic             term_valid,
   input  logic             term_ready,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   fib_state_e       state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d, n_q, n_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, busy_q, done_q;
   logic             core_load, core_step, core_cur_ovf, handshake;
   logic [WIDTH-1:0] core_prev;

   fib_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (core_load),
      .step    (core_step),
      .seed_a  (seed_a),
      .seed_b  (seed_b),
      .prev    (core_prev),
      .cur_ovf (core_cur_ovf)
   );

   assign handshake = valid_q && term_ready;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      ovf_d     = ovf_q;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               ovf_d = 1'b0;
               n_d   = n_terms;
               if (n_terms != '0) begin
                  core_load = 1'b1;
                  idx_d     = '0;
                  state_d   = EMIT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         EMIT: begin
            if (handshake) begin
               if (idx_q == n_q - CNT_ONE) begin
                  state_d = DONE;
               end else begin
                  core_step = 1'b1;
                  idx_d     = idx_q + CNT_ONE;
                  // cur_ovf becomes prev_ovf after this step: the next term would be wrapped.
                  if (core_cur_ovf) begin
                     ovf_d   = 1'b1;
                     state_d = DONE;
                  end
               end
            end
            if (abort) begin
               ovf_d   = ovf_q;
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         n_q     <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         ovf_q   <= ovf_d;
         valid_q <= (state_d == EMIT);
         busy_q  <= (state_d == EMIT);
         done_q  <= (state_d == DONE);
      end
   end

   assign term       = core_prev;
   assign term_idx   = idx_q;
   assign term_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a term scoreboard fed by a reference Fibonacci model.
module tb_fib_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  n_terms;
   logic [31:0] seed_a;
   logic [31:0] seed_b;
   logic        abort;
   logic [31:0] term;
   logic [7:0]  term_idx;
   logic        term_valid;
   logic        term_ready;
   logic        busy;
   logic        done;
   logic        overflow;

   typedef struct packed {
      logic [31:0] term;
      logic [7:0]  idx;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          hs_cnt = 0;
   int          first_hs_cyc = -1;
   int          last_hs_cyc = -1;
   int          last_idx = -1;
   logic [31:0] last_term = '0;
   bit          stall_prev = 1'b0;
   logic [31:0] stall_term;
   logic [7:0]  stall_idx;
   bit          exp_ovf;
   bit          pat [6] = '{1, 0, 0, 1, 0, 1};

   fib_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .n_terms    (n_terms),
      .seed_a     (seed_a),
      .seed_b     (seed_b),
      .abort      (abort),
      .term       (term),
      .term_idx   (term_idx),
      .term_valid (term_valid),
      .term_ready (term_ready),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: unbounded-width Fibonacci, emitting only terms that fit in 32 bits.
   task automatic push_job(input logic [31:0] a, input logic [31:0] b, input int n, output bit ovf);
      longint unsigned p, c, nx;
      p   = 64'(a);
      c   = 64'(b);
      ovf = 1'b0;
      for (int k = 0; k < n; k++) begin
         sb.push_back({p[31:0], 8'(k)});
         if (k == n - 1) break;
         nx = p + c;
         p  = c;
         c  = nx;
         if (p >= 64'h1_0000_0000) begin
            ovf = 1'b1;
            break;
         end
      end
   endtask

   task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic [7:0] n, output int s);
      @(posedge clk);
      #1;
      start   = 1'b1;
      seed_a  = a;
      seed_b  = b;
      n_terms = n;
      @(posedge clk);
      #1;
      start = 1'b0;
      s     = cyc;
   endtask

   task automatic wait_done(input bit use_pat, output int dcyc);
      bit found;
      found = 1'b0;
      dcyc  = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            dcyc  = cyc;
            break;
         end
         @(posedge clk);
         #1;
         if (use_pat) term_ready = pat[i % 6];
      end
      chk("done_seen", 64'(found), 64'd1);
      if (found) begin
         chk("busy_at_done", 64'(busy), 64'd0);
         chk("valid_at_done", 64'(term_valid), 64'd0);
         @(negedge clk);
         chk("done_one_cycle", 64'(done), 64'd0);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_term"}, 64'(term), 64'd0);
      chk({tag, "_idx"}, 64'(term_idx), 64'd0);
      chk({tag, "_valid"}, 64'(term_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow), 64'd0);
   endtask

   // Scoreboard consumer plus stall-stability monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_prev) begin
            chk("stall_valid", 64'(term_valid), 64'd1);
            chk("stall_term", 64'(term), 64'(stall_term));
            chk("stall_idx", 64'(term_idx), 64'(stall_idx));
         end
         if (term_valid && term_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL sb_unexpected: observed idx=%0d term=%0d, expected no term", term_idx, term);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sb_term", 64'(term), 64'(e.term));
               chk("sb_idx", 64'(term_idx), 64'(e.idx));
            end
            $display("xfer cyc=%0d idx=%0d term=%0d", cyc, term_idx, term);
            hs_cnt++;
            last_hs_cyc = cyc;
            last_idx    = int'(term_idx);
            last_term   = term;
            if (term_idx == 8'd0) first_hs_cyc = cyc;
         end
      end
      stall_prev = !rst && !abort && term_valid && !term_ready;
      stall_term = term;
      stall_idx  = term_idx;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int s, d;
      bit seen, got_done;
      rst        = 1'b1;
      start      = 1'b0;
      n_terms    = '0;
      seed_a     = '0;
      seed_b     = '0;
      abort      = 1'b0;
      term_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Job 1: 8 terms, consumer always ready.
      hs_cnt = 0;
      push_job(32'd0, 32'd1, 8, exp_ovf);
      start_job(32'd0, 32'd1, 8'd8, s);
      wait_done(1'b0, d);
      chk("j1_sb_empty", 64'(sb.size()), 64'd0);
      chk("j1_count", 64'(hs_cnt), 64'd8);
      chk("j1_latency", 64'(first_hs_cyc), 64'(s));
      chk("j1_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'd7);
      chk("j1_done_timing", 64'(d), 64'(last_hs_cyc + 1));
      chk("j1_ovf", 64'(overflow), 64'(exp_ovf));

      // Job 2: same job with a stalling consumer.
      hs_cnt = 0;
      push_job(32'd0, 32'd1, 8, exp_ovf);
      start_job(32'd0, 32'd1, 8'd8, s);
      wait_done(1'b1, d);
      term_ready = 1'b1;
      chk("j2_sb_empty", 64'(sb.size()), 64'd0);
      chk("j2_count", 64'(hs_cnt), 64'd8);
      chk("j2_done_timing", 64'(d), 64'(last_hs_cyc + 1));

      // Job 3: overflow stop after F(47).
      hs_cnt = 0;
      push_job(32'd0, 32'd1, 60, exp_ovf);
      start_job(32'd0, 32'd1, 8'd60, s);
      wait_done(1'b0, d);
      chk("j3_sb_empty", 64'(sb.size()), 64'd0);
      chk("j3_last_idx", 64'(last_idx), 64'd47);
      chk("j3_last_term", 64'(last_term), 64'd2971215073);
      chk("j3_done_timing", 64'(d), 64'(last_hs_cyc + 1));
      chk("j3_ovf", 64'(overflow), 64'(exp_ovf));
      repeat (3) @(negedge clk);
      chk("j3_ovf_sticky", 64'(overflow), 64'd1);

      // Job 4: zero-length job clears overflow and emits nothing.
      hs_cnt = 0;
      start_job(32'd7, 32'd9, 8'd0, s);
      @(negedge clk);
      chk("j4_done", 64'(done), 64'd1);
      chk("j4_ovf_cleared", 64'(overflow), 64'd0);
      chk("j4_valid", 64'(term_valid), 64'd0);
      @(negedge clk);
      chk("j4_done_one_cycle", 64'(done), 64'd0);
      chk("j4_count", 64'(hs_cnt), 64'd0);

      // Job 5: abort one cycle after the idx 3 handshake, then a fresh job.
      hs_cnt = 0;
      push_job(32'd0, 32'd1, 10, exp_ovf);
      start_job(32'd0, 32'd1, 8'd10, s);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (term_valid && term_idx == 8'd3) begin
            seen = 1'b1;
            break;
         end
      end
      chk("j5_idx3_seen", 64'(seen), 64'd1);
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("j5_valid_after_abort", 64'(term_valid), 64'd0);
      chk("j5_busy_after_abort", 64'(busy), 64'd0);
      chk("j5_last_idx", 64'(last_idx), 64'd4);
      chk("j5_count", 64'(hs_cnt), 64'd5);
      got_done = done;
      repeat (3) begin
         @(negedge clk);
         got_done = got_done | done;
      end
      chk("j5_no_done", 64'(got_done), 64'd0);
      sb.delete();
      hs_cnt = 0;
      push_job(32'd2, 32'd3, 3, exp_ovf);
      start_job(32'd2, 32'd3, 8'd3, s);
      wait_done(1'b0, d);
      chk("j5b_sb_empty", 64'(sb.size()), 64'd0);
      chk("j5b_count", 64'(hs_cnt), 64'd3);
      chk("j5b_last_term", 64'(last_term), 64'd5);

      // Job 6: start pulse while busy must not disturb the running job.
      hs_cnt = 0;
      push_job(32'd0, 32'd1, 6, exp_ovf);
      start_job(32'd0, 32'd1, 8'd6, s);
      @(posedge clk);
      #1;
      start   = 1'b1;
      seed_a  = 32'd5;
      seed_b  = 32'd5;
      n_terms = 8'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0, d);
      chk("j6_sb_empty", 64'(sb.size()), 64'd0);
      chk("j6_count", 64'(hs_cnt), 64'd6);
      chk("j6_last_term", 64'(last_term), 64'd5);

      // Job 7: reset in the middle of a job.
      push_job(32'd0, 32'd1, 20, exp_ovf);
      start_job(32'd0, 32'd1, 8'd20, s);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      got_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         got_done = got_done | done | term_valid;
      end
      chk("midrst_quiet", 64'(got_done), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Sequencer for the Fibonacci datapath. It accepts a job request (seed pair plus term count) and steps an owned Fibonacci core. Each term is streamed out over a valid/ready interface. The block detects WIDTH-bit overflow and ends the job cleanly before any wrapped term is emitted. It sits between a requesting host or test driver and a downstream term consumer.

## Interface
- WIDTH, 32, term width in bits
- CNT_W, 8, width of term count and index
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- n_terms  in  CNT_W  number of terms to emit; sampled with start
- seed_a  in  WIDTH  term 0; sampled with start
- seed_b  in  WIDTH  term 1; sampled with start
- abort  in  1  cancel the running job
- term  out  WIDTH  current term
- term_idx  out  CNT_W  index of current term, starting at 0
- term_valid  out  1  term/term_idx valid
- term_ready  in  1  consumer accepts term
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at normal or overflow job end
- overflow  out  1  sticky; last job stopped on overflow

## Operation
- Core registers:
  - prev, cur, each with an overflow tag (prev_ovf, cur_ovf).
  - term = prev.
  - load: prev=seed_a, cur=seed_b, both tags cleared.
  - step: prev<=cur, prev_ovf<=cur_ovf; cur<=prev+cur (mod 2^WIDTH), cur_ovf<=carry|prev_ovf|cur_ovf.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start && n_terms!=0 → load core, term_idx=0, overflow cleared, go to EMIT.
  - start && n_terms==0 → overflow cleared, go to DONE; no term is emitted.
- EMIT:
  - term_valid=1.
  - On handshake (term_valid&&term_ready):
    - term_idx==n_terms-1 → DONE.
    - else step the core and increment term_idx. If the new prev_ovf is 1, set overflow and go to DONE; otherwise stay in EMIT.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort in EMIT:
  - A handshake in the same cycle completes and counts.
  - Next state is IDLE: no done pulse, overflow unchanged.
  - abort in IDLE or DONE is ignored.
- start outside IDLE is ignored. Seeds and n_terms are not re-sampled mid-job.
- With seeds 0,1, term k = F(k).

## Timing
- Reset values:
  - state=IDLE.
  - term_valid, busy, done, overflow = 0.
  - term=0, term_idx=0.
  - Core registers = 0.
- Reset mid-job returns to IDLE within one cycle. No done pulse follows.
- Latency: start sampled at edge T → term 0 valid in the cycle after T.
- Throughput: with term_ready held high, one term per cycle.
- done is asserted in the cycle after the final handshake. This also holds for overflow stops.
- For n_terms==0, done is asserted the cycle after start.
- busy=1 exactly while state is EMIT.
- term and term_idx are held stable while term_valid && !term_ready.
- term_valid never drops without a handshake, except on abort or rst.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package fib_pkg:
  - state enum (IDLE, EMIT, DONE).
  - WIDTH and CNT_W defaults.
- Sub-module fib_core:
  - Holds prev/cur plus overflow tags.
  - load and step controls.
  - Single adder with carry out.
- fib_seq_ctrl holds the FSM, the index counter, the n_terms/overflow registers and the output handshake.

## Test plan
- Seeds 0,1, n_terms=8, term_ready=1 → terms 0,1,1,2,3,5,8,13 with idx 0..7 on 8 consecutive cycles. done is asserted one cycle after idx 7, overflow=0, and busy drops together with done.
- Same job, term_ready pattern 1,0,0,1,0,1… → every term appears exactly once, in order. term/term_idx are stable during stalls.
- WIDTH=32, seeds 0,1, n_terms=60 → last term is idx 47 = 2971215073. idx 48 never asserts valid. done pulses, overflow=1 and stays 1 until the next accepted start.
- n_terms=0 → done the cycle after start, term_valid never asserts, overflow=0.
- abort in the cycle after the idx 3 handshake → term_valid=0 and busy=0 next cycle, no done. A following start with seeds 2,3, n_terms=3 yields 2,3,5.
- rst asserted mid-job → all outputs return to their reset values the next cycle. start pulses while busy are ignored: the running job's terms and count are unchanged.
